// File: rtl/xera4_video_scanout.sv
// VGA scanout: walks 640x480@60 timing and shows each video RAM byte (RGB332) as a 4x4 pixel block.
// Latency: counters to pins in 2 pix_ce ticks; frame_start and vblank come 1 clk after their tick.
// Backpressure: none. The block free-runs on pix_ce, and all state holds while pix_ce is low.
module xera4_video_scanout #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0,
    parameter int          FB_WIDTH  = 160,
    parameter logic [14:0] BASE_ADDR = 15'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    output logic [14:0] vram_addr,
    input  logic [7:0]  vram_data,
    output logic        hsync,
    output logic        vsync,
    output logic [2:0]  red,
    output logic [2:0]  green,
    output logic [1:0]  blue,
    output logic        blank,
    output logic        vblank,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [14:0] FB_STEP  = 15'(FB_WIDTH);

    logic [9:0]  h;
    logic [9:0]  v;
    logic [9:0]  h_next;
    logic [9:0]  v_next;
    logic        h_wrap;
    logic        v_wrap;
    logic        hs_raw;
    logic        vs_raw;
    logic        act_raw;
    logic        row_advance;
    logic [14:0] line_base;
    logic [14:0] pix_addr;
    logic        hs1;
    logic        vs1;
    logic        act1;

    always_comb begin
        h_wrap  = (h == H_LAST);
        v_wrap  = (v == V_LAST);
        h_next  = h_wrap ? 10'd0 : h + 10'd1;
        v_next  = h_wrap ? (v_wrap ? 10'd0 : v + 10'd1) : v;
        hs_raw  = (h >= HS_FIRST) && (h <= HS_LAST);
        vs_raw  = (v >= VS_FIRST) && (v <= VS_LAST);
        act_raw = (h < H_ACT) && (v < V_ACT);
        // A frame-buffer row spans four scanlines, so the row base steps after every 4th active line.
        row_advance = h_wrap && (v < V_ACT) && (v[1:0] == 2'd3);
        pix_addr    = line_base + 15'(h[9:2]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h           <= 10'd0;
            v           <= 10'd0;
            line_base   <= BASE_ADDR;
            vram_addr   <= BASE_ADDR;
            hs1         <= 1'b0;
            vs1         <= 1'b0;
            act1        <= 1'b0;
            red         <= 3'd0;
            green       <= 3'd0;
            blue        <= 2'd0;
            blank       <= 1'b1;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce && h_wrap && v_wrap;
            if (pix_ce) begin
                h <= h_next;
                v <= v_next;
                if (h_wrap && v_wrap) begin
                    line_base <= BASE_ADDR;
                end else if (row_advance) begin
                    line_base <= line_base + FB_STEP;
                end
                // Stage A: issue the read and capture the sync and active flags.
                if (act_raw) begin
                    vram_addr <= pix_addr;
                end
                hs1  <= hs_raw;
                vs1  <= vs_raw;
                act1 <= act_raw;
                // Stage B: read data has had at least one clk to settle.
                red    <= act1 ? vram_data[7:5] : 3'd0;
                green  <= act1 ? vram_data[4:2] : 3'd0;
                blue   <= act1 ? vram_data[1:0] : 2'd0;
                blank  <= ~act1;
                hsync  <= hs1 ? HS_POL : ~HS_POL;
                vsync  <= vs1 ? VS_POL : ~VS_POL;
                vblank <= (v_next >= V_ACT);
            end
        end
    end

endmodule

// File: tb/tb_xera4_video_scanout.sv
// Bench for xera4_video_scanout. A reduced-timing instance is checked by scoreboard on every clk.
// A default-timing instance is checked by hand-computed sync and address points.
module tb_xera4_video_scanout;

    // Reduced timing: 48 ticks per line, 22 lines per frame, 8-byte rows, base near the top of memory.
    localparam logic [14:0] SB = 15'h7FF0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        pix_ce;
    logic        data_ff;
    logic [14:0] vram_addr;
    logic [7:0]  vram_data;
    logic        hsync, vsync, blank, vblank, frame_start;
    logic [2:0]  red, green;
    logic [1:0]  blue;

    assign vram_data = data_ff ? 8'hFF : vram_addr[7:0];

    xera4_video_scanout #(
        .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .FB_WIDTH(8), .BASE_ADDR(SB)
    ) u_dut (
        .clk(clk), .reset(reset), .pix_ce(pix_ce),
        .vram_addr(vram_addr), .vram_data(vram_data),
        .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .blank(blank), .vblank(vblank), .frame_start(frame_start)
    );

    logic        rst_f, ce_f;
    logic [14:0] addr_f;
    logic [7:0]  data_f;
    logic        hs_f, vs_f, blank_f, vb_f, fs_f;
    logic [2:0]  r_f, g_f;
    logic [1:0]  b_f;

    assign data_f = addr_f[7:0];

    xera4_video_scanout u_full (
        .clk(clk), .reset(rst_f), .pix_ce(ce_f),
        .vram_addr(addr_f), .vram_data(data_f),
        .hsync(hs_f), .vsync(vs_f),
        .red(r_f), .green(g_f), .blue(b_f),
        .blank(blank_f), .vblank(vb_f), .frame_start(fs_f)
    );

    typedef struct packed {
        logic [14:0] addr;
        logic        hs;
        logic        vs;
        logic        blank;
        logic [7:0]  rgb;
        logic        vblank;
        logic        fs;
    } obs_t;

    typedef struct packed {
        obs_t       o;
        logic [9:0] th;
        logic [9:0] tv;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic full_done = 1'b0;

    // Reference state: counter at the next tick, last issued address, pins owed for the previous tick.
    int          rh, rv;
    logic [14:0] exp_addr;
    logic        p_hs, p_vs, p_blank;
    logic [7:0]  p_rgb;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        rh = 0; rv = 0;
        exp_addr = SB;
        p_hs = 1'b1; p_vs = 1'b1; p_blank = 1'b1; p_rgb = 8'h00;
    endtask

    // One pix_ce tick followed by (period-1) idle clks; pushes the response expected right after the tick.
    task automatic step(input int period);
        logic [14:0] a;
        logic        act, hs, vs;
        int          nh, nv;
        ent_t        e;
        act = (rh < 32) && (rv < 16);
        a   = 15'(32'(SB) + (rv / 4) * 8 + rh / 4);
        hs  = (rh >= 36) && (rh <= 43);
        vs  = (rv >= 18) && (rv <= 19);
        if (act) exp_addr = a;
        nh = (rh == 47) ? 0 : rh + 1;
        nv = (rh == 47) ? ((rv == 21) ? 0 : rv + 1) : rv;
        e.o.addr   = exp_addr;
        e.o.hs     = p_hs;
        e.o.vs     = p_vs;
        e.o.blank  = p_blank;
        e.o.rgb    = p_rgb;
        e.o.vblank = (nv >= 16);
        e.o.fs     = (rh == 47) && (rv == 21);
        e.th       = 10'(rh);
        e.tv       = 10'(rv);
        q.push_back(e);
        p_hs    = ~hs;
        p_vs    = ~vs;
        p_blank = ~act;
        p_rgb   = act ? (data_ff ? 8'hFF : a[7:0]) : 8'h00;
        rh = nh;
        rv = nv;
        pix_ce = 1'b1;
        @(negedge clk);
        pix_ce = 1'b0;
        repeat (period - 1) @(negedge clk);
    endtask

    // Reset is held for 3 clk with pix_ce high to show that reset wins.
    task automatic do_reset(input logic ff);
        reset   = 1'b1;
        pix_ce  = 1'b1;
        data_ff = ff;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        pix_ce = 1'b0;
        model_reset();
    endtask

    // Monitor: pops one entry per pix_ce tick, otherwise expects held outputs (frame_start low).
    initial begin
        obs_t got, last;
        ent_t e;
        logic r, c;
        last = '0;
        forever begin
            @(posedge clk);
            r = reset;
            c = pix_ce;
            #1;
            got = {vram_addr, hsync, vsync, blank, red, green, blue, vblank, frame_start};
            if (r) begin
                last = {SB, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
                check("reset_state", 32'(got), 32'(last));
            end else if (c) begin
                if (q.size() == 0) begin
                    check("sb_underflow", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    check("sb_tick", 32'(got), 32'(e.o));
                    if (e.th == 10'd0 && e.tv == 10'd0)  check("addr_row0", 32'(vram_addr), 32'h7FF0);
                    if (e.th == 10'd4 && e.tv == 10'd0)  check("addr_h4", 32'(vram_addr), 32'h7FF1);
                    if (e.th == 10'd0 && e.tv == 10'd4)  check("addr_row1", 32'(vram_addr), 32'h7FF8);
                    if (e.th == 10'd0 && e.tv == 10'd8)  check("addr_row2_wrap", 32'(vram_addr), 32'h0000);
                    if (e.th == 10'd31 && e.tv == 10'd15) check("addr_last_pix", 32'(vram_addr), 32'h000F);
                    if (e.th == 10'd47 && e.tv == 10'd15) check("vblank_rise", 32'(vblank), 32'd1);
                    if (e.th == 10'd47 && e.tv == 10'd21) check("frame_start_pulse", 32'(frame_start), 32'd1);
                    if (e.th == 10'd5 && e.tv == 10'd0 && !data_ff)
                        check("pix_h4_rgb", 32'({red, green, blue}), 32'hF1);
                    if (e.th == 10'd5 && e.tv == 10'd1 && data_ff)
                        check("pix_ff_rgb", 32'({red, green, blue}), 32'hFF);
                    last    = e.o;
                    last.fs = 1'b0;
                end
            end else begin
                check("hold", 32'(got), 32'(last));
            end
        end
    end

    // Default-timing instance with pix_ce tied high: sync widths and row addressing.
    initial begin
        int   n, fall1, fall2, rise1;
        logic prev;
        rst_f = 1'b1;
        ce_f  = 1'b1;
        fall1 = -1; fall2 = -1; rise1 = -1;
        repeat (3) @(negedge clk);
        rst_f = 1'b0;
        prev  = hs_f;
        n     = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 4)    check("full_addr_h3", 32'(addr_f), 32'd0);
            if (n == 5)    check("full_addr_h4", 32'(addr_f), 32'd1);
            if (n == 6)    check("full_pix_h4", 32'({r_f, g_f, b_f}), 32'h01);
            if (n == 3201) check("full_addr_line4", 32'(addr_f), 32'd160);
            if (n == 3202) check("full_pix_line4", 32'({r_f, g_f, b_f}), 32'hA0);
            if (prev && !hs_f) begin
                if (fall1 < 0) fall1 = n;
                else if (fall2 < 0) fall2 = n;
            end
            if (!prev && hs_f && rise1 < 0) rise1 = n;
            prev = hs_f;
        end
        check("full_hs_first_fall", 32'(fall1), 32'd658);
        check("full_hs_low_width", 32'(rise1 - fall1), 32'd96);
        check("full_hs_period", 32'(fall2 - fall1), 32'd800);
        full_done = 1'b1;
    end

    initial begin
        int waited;
        reset   = 1'b1;
        pix_ce  = 1'b0;
        data_ff = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset(1'b0);

        repeat (2200) step(1);      // two-plus frames, pix_ce constant
        repeat (1200) step(2);      // pix_ce every 2nd clk
        do_reset(1'b1);
        repeat (1100) step(3);      // data forced to 0xFF, pix_ce every 3rd clk
        do_reset(1'b0);
        for (int i = 0; i < 2000; i++) begin
            if (rh == 20 && rv == 10) break;
            step(1);
        end
        check("midframe_reached", 32'(rh * 100 + rv), 32'd2010);
        do_reset(1'b0);             // mid-frame reset; next frame_start only after a full frame
        repeat (1200) step(1);

        waited = 0;
        while (!full_done && waited < 10000) begin
            @(negedge clk);
            waited++;
        end
        check("full_instance_done", 32'(full_done), 32'd1);
        check("sb_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
